// File: rtl/dec_rt_yx.sv
// dec_rt_yx: per-router route decoder for the node-table NoC.
// Decodes a unicast node ID or a multicast bitmap into an output port,
// strips the own-node bit from the bitmap and flags whether a node-table
// lookup is needed for the remaining destinations. One-cycle latency,
// one decode per cycle.
// Optional feature: define DEC_RT_MCAST_EN to build the multicast path;
// without it every request decodes as unicast and the bitmap outputs are 0.
module dec_rt_yx #(
  parameter int unsigned X_POS = 0,
  parameter int unsigned Y_POS = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        um_type,
  input  logic [10:0] addr0,
  input  logic [55:0] addr1,
  output logic        out_valid,
  output logic [2:0]  port,
  output logic [55:0] addr1_rm,
  output logic        multab_en
);

  localparam int unsigned UADDR = 10;
  localparam int unsigned MADDR = 55;
  localparam int unsigned PORTW = 2;
  localparam int unsigned NODES = 56;
  localparam int unsigned OWN   = X_POS * 4 + Y_POS;

  localparam logic [PORTW:0] PORT_L = 3'd0;
  localparam logic [PORTW:0] PORT_N = 3'd1;
  localparam logic [PORTW:0] PORT_E = 3'd2;
  localparam logic [PORTW:0] PORT_S = 3'd3;
  localparam logic [PORTW:0] PORT_W = 3'd4;

  // Y-first dimension-order route for a node ID inside the mesh
  function automatic logic [PORTW:0] route(input logic [5:0] t);
    logic [3:0] tx;
    logic [1:0] ty;
    tx = t[5:2];
    ty = t[1:0];
    if (32'(ty) > Y_POS)      route = PORT_S;
    else if (32'(ty) < Y_POS) route = PORT_N;
    else if (32'(tx) > X_POS) route = PORT_E;
    else if (32'(tx) < X_POS) route = PORT_W;
    else                      route = PORT_L;
  endfunction

  // Unicast decode: out-of-mesh IDs fall back to Local
  function automatic logic [PORTW:0] route_uni(input logic [5:0] t);
    if (t >= 6'(NODES)) route_uni = PORT_L;
    else                route_uni = route(t);
  endfunction

`ifdef DEC_RT_MCAST_EN
  localparam logic [MADDR:0] OWN_MASK = (MADDR+1)'(1) << OWN;

  // Index of the lowest set bit; 0 when the bitmap is empty
  function automatic logic [5:0] lowest(input logic [MADDR:0] bm);
    lowest = 6'd0;
    for (int i = int'(MADDR); i >= 0; i--) begin
      if (bm[i]) lowest = 6'(i);
    end
  endfunction
`endif

  logic            valid_d, valid_q;
  logic [PORTW:0]  port_d, port_q;
  logic [MADDR:0]  rm_d, rm_q;
  logic            me_d, me_q;

  // Upper unicast bits carry no routing information
  logic unused_c;
  assign unused_c = ^{addr0[UADDR:6], um_type, addr1};

  // Next-state decode of the current request
  always_comb begin
    valid_d = 1'b0;
    port_d  = PORT_L;
    rm_d    = '0;
    me_d    = 1'b0;
    if (in_valid) begin
`ifdef DEC_RT_MCAST_EN
      if (um_type) begin
        if (addr1 != '0) begin
          valid_d = 1'b1;
          rm_d    = addr1 & ~OWN_MASK;
          me_d    = |rm_d;
          port_d  = addr1[OWN] ? PORT_L : route(lowest(rm_d));
        end
      end else begin
        valid_d = 1'b1;
        port_d  = route_uni(addr0[5:0]);
      end
`else
      valid_d = 1'b1;
      port_d  = route_uni(addr0[5:0]);
`endif
    end
  end

  // Output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      port_q  <= PORT_L;
      rm_q    <= '0;
      me_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      port_q  <= port_d;
      rm_q    <= rm_d;
      me_q    <= me_d;
    end
  end

  assign out_valid = valid_q;
  assign port      = port_q;
  assign addr1_rm  = rm_q;
  assign multab_en = me_q;

endmodule

// File: tb/tb_dec_rt_yx.sv
// Scoreboard bench for dec_rt_yx at X_POS=0, Y_POS=0.
// The driver pushes one expected output per cycle; the monitor pops and
// compares one cycle later. Multicast expectations follow the build option.
module tb_dec_rt_yx;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        um_type;
  logic [10:0] addr0;
  logic [55:0] addr1;
  logic        out_valid;
  logic [2:0]  port;
  logic [55:0] addr1_rm;
  logic        multab_en;

  always #5 clk = ~clk;

  dec_rt_yx #(.X_POS(0), .Y_POS(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .um_type   (um_type),
    .addr0     (addr0),
    .addr1     (addr1),
    .out_valid (out_valid),
    .port      (port),
    .addr1_rm  (addr1_rm),
    .multab_en (multab_en)
  );

  typedef struct packed {
    logic        v;
    logic [2:0]  port;
    logic [55:0] rm;
    logic        me;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_pop  = 0;

  task automatic check1(input string name, input int idx,
                        input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (item %0d): got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check1("out_valid", n_pop, 64'(out_valid), 64'(e.v));
        check1("port",      n_pop, 64'(port),      64'(e.port));
        check1("addr1_rm",  n_pop, 64'(addr1_rm),  64'(e.rm));
        check1("multab_en", n_pop, 64'(multab_en), 64'(e.me));
        n_pop++;
      end
    end
  end

  task automatic drive(input logic r, input logic iv, input logic um,
                       input logic [10:0] a0, input logic [55:0] a1,
                       input exp_t e);
    @(posedge clk);
    #2;
    rst      = r;
    in_valid = iv;
    um_type  = um;
    addr0    = a0;
    addr1    = a1;
    q.push_back(e);
  endtask

  localparam exp_t ZERO = '0;

  task automatic uc(input logic [10:0] a0, input logic [2:0] p);
    drive(1'b0, 1'b1, 1'b0, a0, 56'hdead_beef_0000, exp_t'{1'b1, p, 56'h0, 1'b0});
  endtask

  task automatic mc(input logic [55:0] a1, input logic v, input logic [2:0] p,
                    input logic [55:0] rm, input logic me);
`ifdef DEC_RT_MCAST_EN
    drive(1'b0, 1'b1, 1'b1, 11'h0, a1, exp_t'{v, p, rm, me});
`else
    drive(1'b0, 1'b1, 1'b1, 11'h0, a1, exp_t'{1'b1, 3'd0, 56'h0, 1'b0});
`endif
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 11'h0, 56'h0, ZERO);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; um_type = 1'b0; addr0 = '0; addr1 = '0;

    // Reset state, then reset beating a simultaneous valid request
    drive(1'b1, 1'b0, 1'b0, 11'h0, 56'h0, ZERO);
    drive(1'b1, 1'b1, 1'b1, 11'h5, 56'h11, ZERO);

    // Multicast vectors
    mc(56'h1,    1'b1, 3'd0, 56'h0,    1'b0);
    mc(56'h11,   1'b1, 3'd0, 56'h10,   1'b1);
    mc(56'h111,  1'b1, 3'd0, 56'h110,  1'b1);
    mc(56'h1100, 1'b1, 3'd2, 56'h1100, 1'b1);
    mc(56'h2,    1'b1, 3'd3, 56'h2,    1'b1);
    mc(56'h80_0000_0000_0000, 1'b1, 3'd3, 56'h80_0000_0000_0000, 1'b1);
    mc(56'h0,    1'b0, 3'd0, 56'h0,    1'b0);

    // Unicast vectors, including ignored upper bits and out-of-mesh ID
    uc(11'd5,    3'd3);
    uc(11'd12,   3'd2);
    uc(11'd0,    3'd0);
    uc(11'h7C5,  3'd3);
    uc(11'd60,   3'd0);
    uc(11'd55,   3'd3);
    idle();

    // Reset pulsed inside a back-to-back stream
    uc(11'd5, 3'd3);
    drive(1'b1, 1'b1, 1'b0, 11'd12, 56'h0, ZERO);
    uc(11'd12, 3'd2);
    mc(56'h1100, 1'b1, 3'd2, 56'h1100, 1'b1);
    idle();

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #3;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
